// File: rtl/sndbus_pkg.sv
// Shared types for the AY sound-bus controller: FSM states and host bus modes.
package sndbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_WAITEND
    } state_t;

    typedef enum logic [1:0] {
        M_INACTIVE,
        M_LATCH,
        M_WRITE,
        M_READ
    } mode_t;

    function automatic mode_t decode_mode(input logic [2:0] bdir_bc2_bc1);
        mode_t m;
        unique case (bdir_bc2_bc1)
            3'b111:  m = M_LATCH;
            3'b110:  m = M_WRITE;
            3'b011:  m = M_READ;
            default: m = M_INACTIVE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sndbus_sync.sv
// Two-flop synchroniser for the asynchronous AY slot controls.
module sndbus_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sndbus_ctrl.sv
// Bridges one AY host slot to up to eight sound chips on a shared local bus,
// with an in-band config write selecting the target chip and status-read mode.
module sndbus_ctrl
    import sndbus_pkg::*;
#(
    parameter int NCHIPS    = 4,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 8,
    parameter int HOLD_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aybdir,
    input  logic              aybc2,
    input  logic              aybc1,
    input  logic              aya8,
    input  logic              aya9_n,
    input  logic [7:0]        ayd_i,
    output logic [7:0]        ayd_o,
    output logic              ayd_oe,
    input  logic [7:0]        d_i,
    output logic [7:0]        d_o,
    output logic              d_oe,
    input  logic [NCHIPS-1:0] chip_en,
    input  logic              multi_ena,
    output logic [NCHIPS-1:0] cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              a0,
    output logic [2:0]        sel,
    output logic              stat,
    output logic              busy
);

    logic [4:0]        raw;
    logic [4:0]        syn;
    logic              hit;
    mode_t             mode;
    state_t            state;
    logic [3:0]        cnt;
    logic              is_rd;
    logic              start;
    logic              cfg;
    logic              cfg_ok;
    logic [7:0]        en_ext;
    logic [NCHIPS-1:0] cs_sel;

    assign raw = {aybdir, aybc2, aybc1, aya8, aya9_n};

    sndbus_sync #(.W(5)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw),
        .q   (syn)
    );

    assign hit    = syn[1] & ~syn[0];
    assign mode   = decode_mode(syn[4:2]);
    assign start  = (state == S_IDLE) && hit && (mode != M_INACTIVE);
    assign cfg    = multi_ena && (mode == M_LATCH) && (ayd_i[7:4] == 4'hF);
    assign en_ext = 8'(chip_en);
    // Out-of-range indices land on zero-extended bits, so this covers both checks.
    assign cfg_ok = en_ext[ayd_i[2:0]];
    assign busy   = (state != S_IDLE);
    assign ayd_oe = hit && (mode == M_READ);

    always_comb begin
        cs_sel = '0;
        for (int i = 0; i < NCHIPS; i++) begin
            cs_sel[i] = (sel == 3'(i)) && chip_en[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            is_rd <= 1'b0;
            cs_n  <= '1;
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            a0    <= 1'b0;
            d_oe  <= 1'b0;
            d_o   <= 8'h00;
            ayd_o <= 8'hFF;
            sel   <= 3'd0;
            stat  <= 1'b0;
        end else begin
            if (!multi_ena) begin
                sel  <= 3'd0;
                stat <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        d_o <= ayd_i;
                        if (cfg) begin
                            stat  <= ayd_i[3];
                            if (cfg_ok) sel <= ayd_i[2:0];
                            state <= S_WAITEND;
                        end else begin
                            is_rd <= (mode == M_READ);
                            a0    <= (mode == M_READ) ? ~stat
                                                      : (mode == M_WRITE);
                            d_oe  <= (mode != M_READ);
                            cs_n  <= ~cs_sel;
                            cnt   <= 4'(SETUP_CYC - 1);
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == 4'd0) begin
                        rd_n  <= ~is_rd;
                        wr_n  <= is_rd;
                        cnt   <= 4'(PULSE_CYC - 1);
                        state <= S_STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_STROBE: begin
                    if (cnt == 4'd0) begin
                        rd_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        if (is_rd) ayd_o <= d_i;
                        cnt   <= 4'(HOLD_CYC - 1);
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 4'd0) begin
                        cs_n  <= '1;
                        d_oe  <= 1'b0;
                        state <= S_WAITEND;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_WAITEND: begin
                    // Hold off until the host cycle ends so one cycle = one access.
                    if (!hit || mode == M_INACTIVE) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sndbus_ctrl.sv
// Bench for sndbus_ctrl: table-driven host cycles checked by a bus monitor
// against a queue of expected accesses, plus reset and overlap sequences.
module tb_sndbus_ctrl;

    localparam logic [2:0] LATCH = 3'b111;
    localparam logic [2:0] WRITE = 3'b110;
    localparam logic [2:0] READ  = 3'b011;

    logic       clk = 1'b0;
    logic       rst;
    logic       aybdir, aybc2, aybc1, aya8, aya9_n;
    logic [7:0] ayd_i, ayd_o, d_i, d_o;
    logic       ayd_oe, d_oe;
    logic [3:0] chip_en, cs_n;
    logic       multi_ena, rd_n, wr_n, a0, stat, busy;
    logic [2:0] sel;

    sndbus_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .aybdir    (aybdir),
        .aybc2     (aybc2),
        .aybc1     (aybc1),
        .aya8      (aya8),
        .aya9_n    (aya9_n),
        .ayd_i     (ayd_i),
        .ayd_o     (ayd_o),
        .ayd_oe    (ayd_oe),
        .d_i       (d_i),
        .d_o       (d_o),
        .d_oe      (d_oe),
        .chip_en   (chip_en),
        .multi_ena (multi_ena),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .a0        (a0),
        .sel       (sel),
        .stat      (stat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] m;
        logic [7:0] d;
        logic       multi;
        logic [3:0] en;
        logic [7:0] di;
        int         hold;
        bit         cfg;
        int         chip;
        logic       a0;
        bit         wr;
        logic [2:0] sel;
        logic       st;
        logic [7:0] rdata;
    } vec_t;

    vec_t       vecs[13];
    vec_t       exq[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_rd;

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endfunction

    // Bus monitor: one observation window per busy period.
    bit         in_win = 0;
    int         k, cs_cnt, cs_first, ob_chip;
    int         wr_cnt, rd_cnt, st_first;
    logic       ob_a0, ob_doe;
    logic [7:0] ob_do;

    always @(negedge clk) begin
        if (busy === 1'b1 && rst === 1'b0) begin
            if (!in_win) begin
                in_win = 1; k = 0; cs_cnt = 0; cs_first = 0; ob_chip = -1;
                wr_cnt = 0; rd_cnt = 0; st_first = 0;
                ob_a0 = 0; ob_doe = 0; ob_do = 0;
            end
            k++;
            chk("cs_onehot", int'($countones(~cs_n) <= 1), 1);
            chk("strobe_excl", int'(!(!rd_n && !wr_n)), 1);
            if (cs_n != 4'hF) begin
                if (cs_cnt == 0) cs_first = k;
                cs_cnt++;
                for (int i = 3; i >= 0; i--) if (!cs_n[i]) ob_chip = i;
            end
            if (!wr_n || !rd_n) begin
                if (wr_cnt + rd_cnt == 0) st_first = k;
                if (!wr_n) wr_cnt++;
                if (!rd_n) rd_cnt++;
                ob_a0 = a0; ob_doe = d_oe; ob_do = d_o;
            end
        end else if (in_win) begin
            in_win = 0;
            if (rst !== 1'b1) begin
                if (exq.size() == 0) begin
                    chk("unexpected_access", 1, 0);
                end else begin
                    vec_t e;
                    e = exq.pop_front();
                    if (e.cfg) begin
                        chk("cfg_cs", cs_cnt, 0);
                        chk("cfg_strobe", wr_cnt + rd_cnt, 0);
                    end else begin
                        chk("cs_len", cs_cnt, e.chip >= 0 ? 12 : 0);
                        if (e.chip >= 0) begin
                            chk("cs_first", cs_first, 1);
                            chk("cs_chip", ob_chip, e.chip);
                        end
                        chk("strobe_first", st_first, 3);
                        chk("wr_len", wr_cnt, e.wr ? 8 : 0);
                        chk("rd_len", rd_cnt, e.wr ? 0 : 8);
                        chk("a0", ob_a0, e.a0);
                        chk("d_oe", ob_doe, e.wr);
                        if (e.wr) chk("d_o", ob_do, e.d);
                        else      chk("ayd_o", ayd_o, e.rdata);
                    end
                    chk("sel", sel, e.sel);
                    chk("stat", stat, e.st);
                end
            end
        end
    end

    task automatic host_on(input logic [2:0] m, input logic [7:0] d);
        ayd_i = d;
        {aybdir, aybc2, aybc1} = m;
        aya8 = 1'b1;
        aya9_n = 1'b0;
    endtask

    task automatic host_off();
        {aybdir, aybc2, aybc1} = 3'b000;
        aya8 = 1'b0;
        aya9_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        repeat (4) @(posedge clk);
        #1;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", busy, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk);
        #1;
        multi_ena = v.multi;
        chip_en = v.en;
        d_i = v.di;
        repeat (2) @(posedge clk);
        #1;
        exq.push_back(v);
        host_on(v.m, v.d);
        if (v.m == READ) begin
            repeat (3) @(posedge clk);
            #1;
            chk("oe_early", ayd_oe, 1);
            chk("rd_prev", ayd_o, last_rd);
            repeat (v.hold - 3) @(posedge clk);
            #1;
            chk("oe_late", ayd_oe, 1);
            chk("rd_data", ayd_o, v.rdata);
        end else begin
            repeat (v.hold) @(posedge clk);
            #1;
        end
        host_off();
        wait_idle();
        if (v.m == READ) begin
            chk("oe_off", ayd_oe, 0);
            last_rd = v.rdata;
        end
    endtask

    function automatic vec_t mk(logic [2:0] m, logic [7:0] d, logic mu,
                                logic [3:0] en, logic [7:0] di, bit cfg,
                                int chip, logic a, bit wr, logic [2:0] s,
                                logic st, logic [7:0] rdata);
        vec_t v;
        v.m = m; v.d = d; v.multi = mu; v.en = en; v.di = di; v.hold = 20;
        v.cfg = cfg; v.chip = chip; v.a0 = a; v.wr = wr;
        v.sel = s; v.st = st; v.rdata = rdata;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(LATCH, 8'h07, 1, 4'hF, 8'h00, 0, 0, 0, 1, 0, 0, 8'hFF);
        vecs[1]  = mk(LATCH, 8'hFA, 1, 4'hF, 8'h00, 1, -1, 0, 0, 2, 1, 8'hFF);
        vecs[2]  = mk(WRITE, 8'h55, 1, 4'hF, 8'h00, 0, 2, 1, 1, 2, 1, 8'hFF);
        vecs[3]  = mk(LATCH, 8'hFB, 1, 4'hF, 8'h00, 1, -1, 0, 0, 3, 1, 8'hFF);
        vecs[4]  = mk(READ,  8'h00, 1, 4'hF, 8'h80, 0, 3, 0, 0, 3, 1, 8'h80);
        vecs[5]  = mk(LATCH, 8'hF2, 1, 4'hF, 8'h00, 1, -1, 0, 0, 2, 0, 8'h80);
        vecs[6]  = mk(READ,  8'h00, 1, 4'hF, 8'h3C, 0, 2, 1, 0, 2, 0, 8'h3C);
        vecs[7]  = mk(LATCH, 8'hF3, 1, 4'h3, 8'h00, 1, -1, 0, 0, 2, 0, 8'h3C);
        vecs[8]  = mk(WRITE, 8'hA5, 1, 4'h3, 8'h00, 0, -1, 1, 1, 2, 0, 8'h3C);
        vecs[9]  = mk(LATCH, 8'hFD, 1, 4'hF, 8'h00, 1, -1, 0, 0, 2, 1, 8'h3C);
        vecs[10] = mk(LATCH, 8'hF1, 0, 4'hF, 8'h00, 0, 0, 0, 1, 0, 0, 8'h3C);
        vecs[11] = mk(READ,  8'h00, 0, 4'hF, 8'h5A, 0, 0, 1, 0, 0, 0, 8'h5A);
        vecs[12] = mk(WRITE, 8'h11, 1, 4'hF, 8'h00, 0, 0, 1, 1, 0, 0, 8'h5A);

        rst = 1'b1;
        host_off();
        ayd_i = 8'h00;
        d_i = 8'h00;
        chip_en = 4'hF;
        multi_ena = 1'b1;
        last_rd = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_rd_n", rd_n, 1);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_a0", a0, 0);
        chk("rst_d_oe", d_oe, 0);
        chk("rst_ayd_oe", ayd_oe, 0);
        chk("rst_ayd_o", ayd_o, 8'hFF);
        chk("rst_d_o", d_o, 0);
        chk("rst_sel", sel, 0);
        chk("rst_stat", stat, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Short host write; a second write arriving during HOLD is ignored.
        @(posedge clk);
        #1;
        exq.push_back(mk(WRITE, 8'h66, 1, 4'hF, 8'h00, 0, 0, 1, 1, 0, 0, 8'h5A));
        host_on(WRITE, 8'h66);
        repeat (2) @(posedge clk);
        #1;
        host_off();
        for (int n = 0; n < 20 && !busy; n++) begin
            @(posedge clk);
            #1;
        end
        chk("short_start", busy, 1);
        repeat (8) @(posedge clk);
        #1;
        host_on(WRITE, 8'h99);
        repeat (6) @(posedge clk);
        #1;
        host_off();
        wait_idle();
        chk("short_data_kept", d_o, 8'h66);
        chk("short_one_access", exq.size(), 0);

        // Reset during the strobe aborts the access on the next edge.
        @(posedge clk);
        #1;
        host_on(WRITE, 8'h77);
        for (int n = 0; n < 40 && wr_n; n++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_strobe", wr_n, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_cs_n", cs_n, 4'hF);
        chk("abort_wr_n", wr_n, 1);
        chk("abort_rd_n", rd_n, 1);
        chk("abort_busy", busy, 0);
        host_off();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd = 8'hFF;
        chk("abort_ayd_o", ayd_o, 8'hFF);
        chk("abort_sel", sel, 0);
        repeat (3) @(posedge clk);
        run_vec(mk(LATCH, 8'h42, 1, 4'hF, 8'h00, 0, 0, 0, 1, 0, 0, 8'hFF));

        chk("queue_empty", exq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
